tx_result_buffer: RTL and testbench

- Buffers ALU results between the result path and tx_uart, so back-to-back operations are not lost while a frame is still shifting out.
- Accepts a one-cycle push strobe with a DATA_BITS result and stores it in a circular FIFO.
- Issues one byte at a time to tx_uart: presents a stable byte and pulses its data-ready input.
- Tracks tx_uart's available flag to know when the next byte may be sent.

---
 rtl/tx_result_buffer.sv | 134 +++++++++++++
 tb/tb_tx_result_buffer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_result_buffer.sv
// tx_result_buffer
//   Circular FIFO between the ALU result path and tx_uart. Results are queued
//   on a one-cycle push strobe and handed to the transmitter one byte per frame.
//   Each byte is presented on a stable register, with a one-cycle start pulse.
//
// Ports
//   i_clock         system clock
//   i_reset         synchronous, active-high reset
//   i_data          result byte to enqueue
//   i_push          one-cycle enqueue strobe
//   i_available_tx  tx_uart idle flag (high = transmitter idle)
//   o_data          registered byte presented to tx_uart
//   o_data_ready    one-cycle start pulse to tx_uart
//   o_empty/o_full  occupancy flags, combinational from the entry count
//   o_count         current occupancy (0..DEPTH)
//   o_overflow      sticky: a push was dropped because the FIFO was full
//   o_tx_error      sticky: tx_uart never went busy after an issue
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for a queued byte and an idle transmitter
// ISSUE     | o_data loaded; start pulse driven for this single cycle
// WAIT_BUSY | waiting for tx_uart to drop its idle flag (bounded by timer)
// WAIT_DONE | frame in flight; waiting for tx_uart to become idle again
module tx_result_buffer #(
  parameter int DATA_BITS   = 8,
  parameter int DEPTH_LOG2  = 2,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [DATA_BITS-1:0]  i_data,
  input  logic                  i_push,
  input  logic                  i_available_tx,
  output logic [DATA_BITS-1:0]  o_data,
  output logic                  o_data_ready,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_tx_error
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TMR_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0]      TMR_LOAD  = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [DEPTH_LOG2:0]   COUNT_MAX = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                 state, state_nxt;
  logic [DATA_BITS-1:0]   mem [DEPTH];
  logic [DEPTH_LOG2-1:0]  wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]    count;
  logic [TMR_W-1:0]       tmr;
  logic                   pop, push_ok, timeout;

  assign o_count = count;
  assign o_empty = (count == '0);
  assign o_full  = (count == COUNT_MAX);

  // A full FIFO still takes a push when the same edge frees a slot.
  assign push_ok = i_push && (!o_full || pop);

  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    timeout      = 1'b0;
    o_data_ready = 1'b0;
    case (state)
      IDLE: begin
        if (!o_empty && i_available_tx) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        o_data_ready = 1'b1;
        state_nxt    = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!i_available_tx) begin
          state_nxt = WAIT_DONE;
        end else if (tmr == '0) begin
          // transmitter never accepted the byte; give up on it
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_DONE: begin
        if (i_available_tx) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_data     <= '0;
      o_overflow <= 1'b0;
      o_tx_error <= 1'b0;
      tmr        <= '0;
    end else begin
      state <= state_nxt;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        o_data <= mem[rd_ptr];
      end
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (pop && !push_ok) count <= count - 1'b1;
      if (i_push && !push_ok) o_overflow <= 1'b1;
      if (timeout)            o_tx_error <= 1'b1;
      // down-counter: loaded while issuing, terminal count at zero
      if (state == ISSUE)                      tmr <= TMR_LOAD;
      else if (state == WAIT_BUSY && tmr != '0) tmr <= tmr - 1'b1;
    end
  end

  // storage carries no reset; contents are only read behind a valid count
  always_ff @(posedge i_clock) begin
    if (push_ok) mem[wr_ptr] <= i_data;
  end

endmodule

// File: tb/tb_tx_result_buffer.sv
module tb_tx_result_buffer;

  localparam int ACK_TIMEOUT = 1024;
  localparam int BUSY_LEN    = 100;

  logic        i_clock;
  logic        i_reset;
  logic [7:0]  i_data;
  logic        i_push;
  logic        i_available_tx;
  logic [7:0]  o_data;
  logic        o_data_ready;
  logic        o_empty;
  logic        o_full;
  logic [2:0]  o_count;
  logic        o_overflow;
  logic        o_tx_error;

  int          n_checks;
  int          n_errors;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_b;
  logic        tx_hold;
  logic        tx_ignore;
  int          drop_cnt;
  int          busy_cnt;

  tx_result_buffer #(
    .DATA_BITS   (8),
    .DEPTH_LOG2  (2),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_data         (i_data),
    .i_push         (i_push),
    .i_available_tx (i_available_tx),
    .o_data         (o_data),
    .o_data_ready   (o_data_ready),
    .o_empty        (o_empty),
    .o_full         (o_full),
    .o_count        (o_count),
    .o_overflow     (o_overflow),
    .o_tx_error     (o_tx_error)
  );

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_errors++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  // one push per call; accepted bytes go to the scoreboard
  task automatic push_byte(input logic [7:0] d, input bit accepted);
    i_data = d;
    i_push = 1'b1;
    if (accepted) exp_q.push_back(d);
    tick();
    i_push = 1'b0;
  endtask

  task automatic wait_pulse(input string tag, input int max);
    int n;
    n = 0;
    @(negedge i_clock);
    while (n < max && o_data_ready !== 1'b1) begin
      @(negedge i_clock);
      n++;
    end
    chk(tag, o_data_ready, 1);
  endtask

  task automatic wait_drain(input string tag, input int max);
    int   n;
    logic done;
    n    = 0;
    done = 1'b0;
    while (n < max && !done) begin
      @(negedge i_clock);
      done = (exp_q.size() == 0) && (drop_cnt == 0) && (busy_cnt == 0);
      n++;
    end
    chk(tag, done, 1);
    tick();
    tick();
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    tx_hold        = 1'b0;
    tx_ignore      = 1'b0;
    drop_cnt       = 0;
    busy_cnt       = 0;
    i_available_tx = 1'b1;
    i_reset        = 1'b1;
    i_push         = 1'b0;
    i_data         = '0;

    fork
      // tx_uart model: goes busy 3 clocks after a start pulse, idle BUSY_LEN later
      forever begin
        @(negedge i_clock);
        if (busy_cnt > 0) busy_cnt--;
        if (drop_cnt > 0) begin
          drop_cnt--;
          if (drop_cnt == 0) busy_cnt = BUSY_LEN;
        end
        if (o_data_ready === 1'b1 && !tx_ignore) drop_cnt = 3;
        i_available_tx = !(tx_hold || busy_cnt > 0);
      end
      // scoreboard: every start pulse must carry the oldest expected byte
      forever begin
        @(negedge i_clock);
        if (o_data_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pulse", {31'd0, o_data_ready}, 0);
          end else begin
            exp_b = exp_q.pop_front();
            chk("tx_byte", o_data, exp_b);
          end
        end
      end
    join_none

    // reset state and quiet idle
    tick(); tick(); tick();
    i_reset = 1'b0;
    @(negedge i_clock);
    chk("rst_empty", o_empty, 1);
    chk("rst_count", o_count, 0);
    chk("rst_full", o_full, 0);
    chk("rst_data", o_data, 0);
    chk("rst_overflow", o_overflow, 0);
    chk("rst_tx_error", o_tx_error, 0);
    repeat (50) @(negedge i_clock);

    // single byte, two-clock latency
    tick();
    push_byte(8'hA5, 1'b0);
    @(negedge i_clock);
    chk("lat_cycle1_ready", o_data_ready, 0);
    chk("lat_cycle1_count", o_count, 1);
    exp_q.push_back(8'hA5);
    @(negedge i_clock);
    chk("lat_cycle2_ready", o_data_ready, 1);
    wait_drain("drain_a5", 300);
    @(negedge i_clock);
    chk("a5_empty", o_empty, 1);
    chk("a5_data_held", o_data, 8'hA5);

    // fill while transmitter busy, then overflow
    tx_hold = 1'b1;
    tick();
    push_byte(8'h01, 1'b1);
    push_byte(8'h02, 1'b1);
    push_byte(8'h03, 1'b1);
    push_byte(8'h04, 1'b1);
    @(negedge i_clock);
    chk("fill_full", o_full, 1);
    chk("fill_count", o_count, 4);
    chk("fill_no_overflow", o_overflow, 0);
    tick();
    push_byte(8'h05, 1'b0);
    @(negedge i_clock);
    chk("ovf_flag", o_overflow, 1);
    chk("ovf_count", o_count, 4);
    chk("ovf_data_held", o_data, 8'hA5);
    tick();
    tx_hold = 1'b0;
    wait_drain("drain_fill", 1000);
    @(negedge i_clock);
    chk("fill_drained_empty", o_empty, 1);

    // push lands on the same edge as the pop from a full FIFO
    tx_hold = 1'b1;
    tick();
    push_byte(8'h11, 1'b1);
    push_byte(8'h12, 1'b1);
    push_byte(8'h13, 1'b1);
    push_byte(8'h14, 1'b1);
    @(negedge i_clock);
    chk("coinc_full", o_full, 1);
    tick();
    tx_hold = 1'b0;
    push_byte(8'h15, 1'b1);
    @(negedge i_clock);
    chk("coinc_issue", o_data_ready, 1);
    chk("coinc_count", o_count, 4);
    wait_drain("drain_coinc", 1000);

    // acknowledge timeout: transmitter never goes busy
    tx_hold = 1'b1;
    tick();
    push_byte(8'h21, 1'b1);
    push_byte(8'h22, 1'b1);
    tx_ignore = 1'b1;
    tx_hold   = 1'b0;
    wait_pulse("to_first_pulse", 20);
    repeat (ACK_TIMEOUT - 1) @(negedge i_clock);
    @(negedge i_clock);
    chk("to_before", o_tx_error, 0);
    @(negedge i_clock);
    chk("to_after", o_tx_error, 1);
    @(negedge i_clock);
    chk("to_next_issue", o_data_ready, 1);
    repeat (ACK_TIMEOUT + 10) @(negedge i_clock);
    tx_ignore = 1'b0;
    chk("to_empty", o_empty, 1);

    // reset while a frame is in flight with two bytes queued
    tick();
    tx_hold = 1'b1;
    tick();
    push_byte(8'h31, 1'b1);
    push_byte(8'h32, 1'b1);
    push_byte(8'h33, 1'b1);
    tx_hold = 1'b0;
    wait_pulse("rst_mid_pulse", 20);
    repeat (10) @(negedge i_clock);
    chk("rst_mid_count_before", o_count, 2);
    tick();
    i_reset = 1'b1;
    exp_q.delete();
    tick();
    i_reset = 1'b0;
    @(negedge i_clock);
    chk("rst_mid_count", o_count, 0);
    chk("rst_mid_empty", o_empty, 1);
    chk("rst_mid_data", o_data, 0);
    chk("rst_mid_overflow", o_overflow, 0);
    chk("rst_mid_tx_error", o_tx_error, 0);
    repeat (300) @(negedge i_clock);
    chk("rst_mid_quiet_empty", o_empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
